// File: rtl/spike_encoder.sv
// spike_encoder: latency-coded spike-time encoder.
// Pixels stream into a shadow buffer. A full shadow is swapped into the active
// spike-time bank at a frame boundary, or at once when no frame is running.
// Each frame lasts TRAIN_PERIOD or TEST_PERIOD cycles, depending on the mode
// latched at the swap.
// Optional feature macro: SPIKE_THRESH_EN. When it is defined, pixels dimmer
// than THRESH encode to the all-ones (no useful spike) time.
module spike_encoder #(
  parameter int NUM_INPUTS   = 64,
  parameter int PIX_W        = 8,
  parameter int TIME_W       = 4,
  parameter int TRAIN_PERIOD = 16,
  parameter int TEST_PERIOD  = 8,
  parameter int THRESH       = 32
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         training,
  input  logic                         pix_valid,
  input  logic [PIX_W-1:0]             pix_data,
  output logic                         pix_ready,
  output logic [NUM_INPUTS*TIME_W-1:0] spike_times,
  output logic [TIME_W:0]              time_val,
  output logic                         training_q,
  output logic                         frame_start,
  output logic                         frame_last,
  output logic                         running
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
  localparam logic [TIME_W:0]   TRAIN_LAST = (TIME_W+1)'(TRAIN_PERIOD - 1);
  localparam logic [TIME_W:0]   TEST_LAST  = (TIME_W+1)'(TEST_PERIOD - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                         r_state;
  logic [IDX_W-1:0]               r_wr_idx;
  logic                           r_shadow_full;
  logic [TIME_W-1:0]              r_shadow [NUM_INPUTS];
  logic [NUM_INPUTS*TIME_W-1:0]   r_spike_times;
  logic [TIME_W:0]                r_time_val;
  logic                           r_training_q;
  logic                           r_frame_start;
  logic                           r_running;

  logic [TIME_W-1:0]              w_lin;
  logic [TIME_W-1:0]              w_enc;
  logic                           w_accept;
  logic [TIME_W:0]                w_last_tv;
  logic                           w_at_end;
  logic                           w_swap;
  logic [NUM_INPUTS*TIME_W-1:0]   w_shadow_flat;

  // Linear latency code: invert the intensity and keep the top TIME_W bits,
  // so the brightest pixel fires at time 0.
  assign w_lin = TIME_W'((~pix_data) >> (PIX_W - TIME_W));

`ifdef SPIKE_THRESH_EN
  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);
  assign w_enc = (pix_data < THRESH_V) ? {TIME_W{1'b1}} : w_lin;
`else
  logic w_thresh_unused;
  assign w_thresh_unused = (THRESH != 0);
  assign w_enc = w_lin;
`endif

  // A full shadow exerts backpressure; its contents wait for the next swap.
  assign w_accept  = pix_valid && !r_shadow_full;
  assign w_last_tv = r_training_q ? TRAIN_LAST : TEST_LAST;
  assign w_at_end  = (r_state == S_RUN) && (r_time_val == w_last_tv);
  // The registered full flag is used here. A last pixel arriving on a boundary
  // cycle is therefore swapped one cycle later, through IDLE.
  assign w_swap    = r_shadow_full && ((r_state == S_IDLE) || w_at_end);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_flat
      assign w_shadow_flat[gi*TIME_W +: TIME_W] = r_shadow[gi];
    end
  endgenerate

  // Shadow storage: the encoded pixel is written at the current load index.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow[r_wr_idx] <= w_enc;
    end
  end

  // Load index and full flag: the last pixel of an image marks the shadow full.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_idx      <= '0;
      r_shadow_full <= 1'b0;
    end else if (w_swap) begin
      r_shadow_full <= 1'b0;
    end else if (w_accept) begin
      if (r_wr_idx == LAST_IDX) begin
        r_wr_idx      <= '0;
        r_shadow_full <= 1'b1;
      end else begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
    end
  end

  // Frame control FSM: swap images, count frame cycles, drop to IDLE when starved.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= S_IDLE;
      r_spike_times <= '1;
      r_time_val    <= '0;
      r_training_q  <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_swap) begin
        r_state       <= S_RUN;
        r_spike_times <= w_shadow_flat;
        r_time_val    <= '0;
        r_training_q  <= training;
        r_frame_start <= 1'b1;
        r_running     <= 1'b1;
      end else if (r_state == S_RUN) begin
        if (w_at_end) begin
          r_state    <= S_IDLE;
          r_time_val <= '0;
          r_running  <= 1'b0;
        end else begin
          r_time_val <= r_time_val + 1'b1;
        end
      end
    end
  end

  assign pix_ready   = !r_shadow_full;
  assign spike_times = r_spike_times;
  assign time_val    = r_time_val;
  assign training_q  = r_training_q;
  assign frame_start = r_frame_start;
  assign frame_last  = w_at_end;
  assign running     = r_running;

endmodule

// File: tb/tb_spike_encoder.sv
// Testbench for spike_encoder. Expected spike vectors and modes are queued as
// images are streamed in, and are checked when frame_start appears.
// The image size is reduced to 12 pixels. A full image then loads within one
// 16-cycle training frame, so the back-to-back and boundary cases can occur.
module tb_spike_encoder;
  localparam int N       = 12;
  localparam int PIX_W   = 8;
  localparam int TIME_W  = 4;
  localparam int TRAIN_P = 16;
  localparam int TEST_P  = 8;
  localparam int THRESH  = 32;

  logic                   clk = 1'b0;
  logic                   rst_l = 1'b1;
  logic                   training = 1'b0;
  logic                   pix_valid = 1'b0;
  logic [PIX_W-1:0]       pix_data = '0;
  logic                   pix_ready;
  logic [N*TIME_W-1:0]    spike_times;
  logic [TIME_W:0]        time_val;
  logic                   training_q;
  logic                   frame_start;
  logic                   frame_last;
  logic                   running;

  spike_encoder #(
    .NUM_INPUTS(N), .PIX_W(PIX_W), .TIME_W(TIME_W),
    .TRAIN_PERIOD(TRAIN_P), .TEST_PERIOD(TEST_P), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .training(training), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .spike_times(spike_times),
    .time_val(time_val), .training_q(training_q), .frame_start(frame_start),
    .frame_last(frame_last), .running(running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames = 0;
  int drv_cnt = 0;
  int last_drv_cyc = -100;
  int fs_cyc = -1;
  int img [N];
  int pix_q [$];
  logic [N*TIME_W-1:0] exp_spk_q [$];
  logic                exp_trn_q [$];
  logic [N*TIME_W-1:0] all_ones = '1;

  // Reference encoding taken straight from the intensity formula.
  function automatic logic [TIME_W-1:0] enc(input int p);
    int e;
    e = ((1 << PIX_W) - 1 - p) >> (PIX_W - TIME_W);
`ifdef SPIKE_THRESH_EN
    if (p < THRESH) e = (1 << TIME_W) - 1;
`endif
    return TIME_W'(e);
  endfunction

  task automatic push_image(input logic trn);
    logic [N*TIME_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      pix_q.push_back(img[i]);
      v[i*TIME_W +: TIME_W] = enc(img[i]);
    end
    exp_spk_q.push_back(v);
    exp_trn_q.push_back(trn);
  endtask

  // One cycle: observe on the falling edge, compare any new frame against the
  // scoreboard, then drive the next pixel. While backpressured, junk data is
  // driven so that a wrongly accepted pixel corrupts the image.
  task automatic tick();
    logic [N*TIME_W-1:0] ev;
    logic                et;
    @(negedge clk);
    cyc++;
    if (frame_start === 1'b1) begin
      fs_cyc = cyc;
      frames++;
      checks++;
      if (exp_spk_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: frame_start=1 at cycle %0d with no image queued", cyc);
      end else begin
        ev = exp_spk_q.pop_front();
        et = exp_trn_q.pop_front();
        $display("frame %0d at cycle %0d: spike_times=%h training_q=%b", frames, cyc, spike_times, training_q);
        if (spike_times !== ev) begin
          errors++;
          $display("FAIL frame_spikes: got %h expected %h", spike_times, ev);
        end
        checks++;
        if (training_q !== et) begin
          errors++;
          $display("FAIL frame_mode: training_q got %b expected %b", training_q, et);
        end
      end
    end
    if (pix_q.size() > 0) begin
      pix_valid = 1'b1;
      if (pix_ready === 1'b1) begin
        pix_data = PIX_W'(pix_q.pop_front());
        drv_cnt++;
        if (drv_cnt % N == 0) last_drv_cyc = cyc;
      end else begin
        pix_data = '0;
      end
    end else begin
      pix_valid = 1'b0;
      pix_data  = '0;
    end
  endtask

  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    tick();
    while (frame_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: frame_start=%b after %0d cycles, required 1", tag, frame_start, n);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (running !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: running=%b after %0d cycles, required 0", tag, running, n);
    end
  endtask

  task automatic test_reset();
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1 || running !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/run/start/last got %b%b%b%b expected 1000", pix_ready, running, frame_start, frame_last);
    end
    checks++;
    if (spike_times !== all_ones) begin
      errors++;
      $display("FAIL reset_spikes: got %h expected %h", spike_times, all_ones);
    end
    checks++;
    if (time_val !== '0 || training_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_time_mode: time_val %0d training_q %b expected 0 0", time_val, training_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pix_ready %b running %b expected 1 0", pix_ready, running);
    end
  endtask

  task automatic test_bright_frame();
    training = 1'b1;
    for (int i = 0; i < N; i++) img[i] = 255;
    push_image(1'b1);
    wait_frame_start("bright");
    checks++;
    if (fs_cyc - last_drv_cyc != 2) begin
      errors++;
      $display("FAIL bright_latency: frame_start %0d cycles after last pixel drive, required 2", fs_cyc - last_drv_cyc);
    end
    checks++;
    if (spike_times !== '0) begin
      errors++;
      $display("FAIL bright_spikes: got %h expected all zero", spike_times);
    end
    for (int k = 0; k < TRAIN_P; k++) begin
      if (k > 0) tick();
      checks++;
      if (time_val !== (TIME_W+1)'(k) || frame_last !== (k == TRAIN_P-1) || running !== 1'b1) begin
        errors++;
        $display("FAIL bright_count: step %0d time_val %0d frame_last %b running %b", k, time_val, frame_last, running);
      end
    end
    tick();
    checks++;
    if (running !== 1'b0 || time_val !== '0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
      errors++;
      $display("FAIL starve_enter: running %b time_val %0d start %b last %b expected 0 0 0 0", running, time_val, frame_start, frame_last);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (running !== 1'b0 || time_val !== '0 || frame_last !== 1'b0 || spike_times !== '0) begin
        errors++;
        $display("FAIL starve_hold: running %b time_val %0d last %b spikes %h", running, time_val, frame_last, spike_times);
      end
    end
  endtask

  task automatic test_pattern();
    int exp_pat [6];
    exp_pat[0] = 15; exp_pat[1] = 14; exp_pat[2] = 7; exp_pat[3] = 0;
`ifdef SPIKE_THRESH_EN
    exp_pat[4] = 15;
`else
    exp_pat[4] = 14;
`endif
    exp_pat[5] = 13;
    for (int i = 0; i < N; i++) img[i] = 255;
    img[0] = 0; img[1] = 16; img[2] = 128; img[3] = 240; img[4] = 31; img[5] = 32;
    push_image(1'b1);
    wait_frame_start("pattern");
    checks++;
    if (fs_cyc - last_drv_cyc != 2) begin
      errors++;
      $display("FAIL pattern_latency: frame_start %0d cycles after last pixel drive, required 2", fs_cyc - last_drv_cyc);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (spike_times[i*TIME_W +: TIME_W] !== TIME_W'(exp_pat[i])) begin
        errors++;
        $display("FAIL pattern_pix%0d: got %0d expected %0d", i, spike_times[i*TIME_W +: TIME_W], exp_pat[i]);
      end
    end
    wait_idle("pattern");
  endtask

  task automatic test_boundary();
    for (int i = 0; i < N; i++) img[i] = i * 7;
    push_image(1'b1);
    wait_frame_start("bnd_first");
    for (int k = 0; k < 3; k++) tick();
    for (int i = 0; i < N; i++) img[i] = 250 - i * 9;
    push_image(1'b1);
    for (int k = 4; k < TRAIN_P; k++) begin
      tick();
      checks++;
      if (time_val !== (TIME_W+1)'(k) || pix_ready !== 1'b1 || frame_last !== (k == TRAIN_P-1)) begin
        errors++;
        $display("FAIL bnd_count: step %0d time_val %0d pix_ready %b frame_last %b", k, time_val, pix_ready, frame_last);
      end
    end
    tick();
    checks++;
    if (running !== 1'b0 || frame_start !== 1'b0 || time_val !== '0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL bnd_idle: running %b start %b time_val %0d pix_ready %b expected 0 0 0 0", running, frame_start, time_val, pix_ready);
    end
    tick();
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1 || time_val !== '0 || fs_cyc - last_drv_cyc != 2) begin
      errors++;
      $display("FAIL bnd_swap: start %b running %b time_val %0d latency %0d expected 1 1 0 2", frame_start, running, time_val, fs_cyc - last_drv_cyc);
    end
    wait_idle("bnd");
  endtask

  task automatic test_back_to_back();
    training = 1'b1;
    for (int i = 0; i < N; i++) img[i] = i * 21;
    push_image(1'b1);
    for (int i = 0; i < N; i++) img[i] = 255 - i * 17;
    push_image(1'b0);
    wait_frame_start("b2b_a");
    training = 1'b0;
    for (int k = 0; k < TRAIN_P; k++) begin
      if (k > 0) tick();
      checks++;
      if (time_val !== (TIME_W+1)'(k) || frame_last !== (k == TRAIN_P-1) || pix_ready !== (k < N)) begin
        errors++;
        $display("FAIL b2b_frame_a: step %0d time_val %0d frame_last %b pix_ready %b", k, time_val, frame_last, pix_ready);
      end
    end
    tick();
    checks++;
    if (frame_start !== 1'b1 || time_val !== '0 || running !== 1'b1 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_swap: start %b time_val %0d running %b pix_ready %b expected 1 0 1 1", frame_start, time_val, running, pix_ready);
    end
    for (int k = 1; k < TEST_P; k++) begin
      tick();
      checks++;
      if (time_val !== (TIME_W+1)'(k) || frame_last !== (k == TEST_P-1) || running !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame_b: step %0d time_val %0d frame_last %b running %b", k, time_val, frame_last, running);
      end
    end
    tick();
    checks++;
    if (running !== 1'b0 || time_val !== '0) begin
      errors++;
      $display("FAIL b2b_end: running %b time_val %0d expected 0 0", running, time_val);
    end
  endtask

  task automatic test_reset_mid();
    training = 1'b1;
    for (int i = 0; i < N; i++) img[i] = i * 20 + 3;
    push_image(1'b1);
    for (int k = 0; k < 5; k++) tick();
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1 || running !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0 ||
        time_val !== '0 || training_q !== 1'b0 || spike_times !== all_ones) begin
      errors++;
      $display("FAIL rmid_load: ready %b run %b start %b last %b tv %0d tq %b spikes %h", pix_ready, running,
               frame_start, frame_last, time_val, training_q, spike_times);
    end
    pix_q.delete();
    exp_spk_q.delete();
    exp_trn_q.delete();
    drv_cnt   = 0;
    pix_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < N; i++) img[i] = i * 20;
    push_image(1'b1);
    wait_frame_start("reload");
    checks++;
    if (fs_cyc - last_drv_cyc != 2) begin
      errors++;
      $display("FAIL reload_latency: frame_start %0d cycles after last pixel drive, required 2", fs_cyc - last_drv_cyc);
    end
    for (int k = 0; k < 3; k++) tick();
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (running !== 1'b0 || time_val !== '0 || training_q !== 1'b0 || spike_times !== all_ones || frame_last !== 1'b0) begin
      errors++;
      $display("FAIL rmid_frame: run %b tv %0d tq %b last %b spikes %h", running, time_val, training_q, frame_last, spike_times);
    end
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (running !== 1'b0 || frame_start !== 1'b0 || time_val !== '0) begin
        errors++;
        $display("FAIL rmid_resume: run %b start %b tv %0d expected 0 0 0", running, frame_start, time_val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bright_frame();
    test_pattern();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_spk_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing: %0d queued frames never started, required 0", exp_spk_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
